pcie_load_scheduler: RTL and testbench

//  Sequences one per-layer parameter load from the PCIe stream into the bias RAM and then the weight RAM.

---
 rtl/pcie_load_scheduler.sv | 150 +++++++++++++++
 tb/tb_pcie_load_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_load_scheduler.sv
// pcie_load_scheduler: sequences one per-layer parameter load from the PCIe stream,
// first into the bias RAM, then into the weight RAM, after clearing both RAMs.
// Latency: loadStart -> first write 2 cycles (CLEAR, first BIAS cycle); last word -> loadDone 1 cycle.
// Backpressure: pcieReady drops while the active RAM is full or ena=0; the source holds its word.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   ena                           run enable; 0 freezes state/counters and blocks transfers
//   loadStart/loadLayer           load request plus layer index (latched on accept)
//   biasCount/weightCount         word counts for the two phases (latched on accept)
//   pcieValid, biasFull, weightFull   stream valid and RAM full flags
//   pcieReady, biasWriteEn, weightWriteEn   combinational handshake / write strobes
//   biasRst, weightRst            registered 1-cycle RAM clears
//   curLayer, loadBusy, loadDone, pcieDataReady, startDropped   status
module pcie_load_scheduler #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             loadStart,
  input  logic [3:0]       loadLayer,
  input  logic [CNT_W-1:0] biasCount,
  input  logic [CNT_W-1:0] weightCount,
  input  logic             pcieValid,
  input  logic             biasFull,
  input  logic             weightFull,
  output logic             pcieReady,
  output logic             biasWriteEn,
  output logic             weightWriteEn,
  output logic             biasRst,
  output logic             weightRst,
  output logic [3:0]       curLayer,
  output logic             loadBusy,
  output logic             loadDone,
  output logic             pcieDataReady,
  output logic             startDropped
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    BIAS   = 3'd2,
    WEIGHT = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W-1:0] bias_len;
  logic [CNT_W-1:0] weight_len;
  logic             accept;
  logic             clr_q;
  logic             drop_q;
  logic             ready_q;

  // Compare against len-1 rather than incrementing and comparing to len, so an
  // all-ones count never needs a counter value beyond CNT_W bits.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    accept        = 1'b0;
    pcieReady     = 1'b0;
    biasWriteEn   = 1'b0;
    weightWriteEn = 1'b0;
    loadDone      = 1'b0;
    if (ena) begin
      case (state)
        IDLE: begin
          if (loadStart) begin
            accept   = 1'b1;
            state_nx = CLEAR;
          end
        end
        CLEAR: begin
          cnt_nx = '0;
          if (bias_len != '0)        state_nx = BIAS;
          else if (weight_len != '0) state_nx = WEIGHT;
          else                       state_nx = DONE;
        end
        BIAS: begin
          pcieReady = ~biasFull;
          if (pcieValid && !biasFull) begin
            biasWriteEn = 1'b1;
            if (cnt == bias_len - CNT_W'(1)) begin
              cnt_nx   = '0;
              state_nx = (weight_len != '0) ? WEIGHT : DONE;
            end else begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end
        end
        WEIGHT: begin
          pcieReady = ~weightFull;
          if (pcieValid && !weightFull) begin
            weightWriteEn = 1'b1;
            if (cnt == weight_len - CNT_W'(1)) begin
              cnt_nx   = '0;
              state_nx = DONE;
            end else begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          loadDone = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bias_len   <= '0;
      weight_len <= '0;
      curLayer   <= '0;
      clr_q      <= 1'b0;
      drop_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      // The clear pulse lands in the CLEAR cycle because it is registered on accept.
      clr_q  <= accept;
      drop_q <= ena & loadStart & (state != IDLE);
      if (accept) begin
        bias_len   <= biasCount;
        weight_len <= weightCount;
        curLayer   <= loadLayer;
        ready_q    <= 1'b0;
      end else if (state != DONE && state_nx == DONE) begin
        // Set on entry so the level is already high during the loadDone cycle.
        ready_q <= 1'b1;
      end
    end
  end

  assign biasRst       = clr_q;
  assign weightRst     = clr_q;
  assign startDropped  = drop_q;
  assign pcieDataReady = ready_q;
  assign loadBusy      = (state != IDLE);

endmodule

// File: tb/tb_pcie_load_scheduler.sv
module tb_pcie_load_scheduler;
  localparam int W = 5;  // narrow counters so an all-ones count is simulable

  localparam int P_IDLE = 0, P_CLEAR = 1, P_BIAS = 2, P_WEIGHT = 3, P_DONE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b0;
  logic loadStart = 1'b0;
  logic [3:0] loadLayer = '0;
  logic [W-1:0] biasCount = '0;
  logic [W-1:0] weightCount = '0;
  logic pcieValid = 1'b0, biasFull = 1'b0, weightFull = 1'b0;
  logic pcieReady, biasWriteEn, weightWriteEn, biasRst, weightRst;
  logic [3:0] curLayer;
  logic loadBusy, loadDone, pcieDataReady, startDropped;

  pcie_load_scheduler #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .loadStart(loadStart), .loadLayer(loadLayer),
    .biasCount(biasCount), .weightCount(weightCount), .pcieValid(pcieValid),
    .biasFull(biasFull), .weightFull(weightFull), .pcieReady(pcieReady),
    .biasWriteEn(biasWriteEn), .weightWriteEn(weightWriteEn), .biasRst(biasRst),
    .weightRst(weightRst), .curLayer(curLayer), .loadBusy(loadBusy), .loadDone(loadDone),
    .pcieDataReady(pcieDataReady), .startDropped(startDropped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: phase plus words remaining in the phase.
  int m_ph = P_IDLE, m_rem = 0, m_b = 0, m_w = 0, m_layer = 0;
  bit m_dr = 0, m_clr = 0, m_drop = 0;

  int n_chk = 0, n_fail = 0;
  int bw_cnt = 0, ww_cnt = 0, done_cnt = 0, drop_cnt = 0, clr_cnt = 0, done_cyc = 0, st_cyc = 0;

  function automatic logic [12:0] outs();
    return {pcieReady, biasWriteEn, weightWriteEn, biasRst, weightRst, curLayer,
            loadBusy, loadDone, pcieDataReady, startDropped};
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [12:0] exp_v;
    logic [12:0] act_v;
    bit rdy, bwe, wwe, xfer;
    act_v = outs();
    if (rst) begin
      m_ph = P_IDLE; m_rem = 0; m_b = 0; m_w = 0; m_layer = 0;
      m_dr = 0; m_clr = 0; m_drop = 0;
      exp_v = '0;
    end else begin
      rdy = ena && ((m_ph == P_BIAS && !biasFull) || (m_ph == P_WEIGHT && !weightFull));
      xfer = rdy && pcieValid;
      bwe = xfer && m_ph == P_BIAS;
      wwe = xfer && m_ph == P_WEIGHT;
      exp_v = {rdy, bwe, wwe, m_clr, m_clr, 4'(m_layer), m_ph != P_IDLE,
               ena && m_ph == P_DONE, m_dr, m_drop};
    end
    n_chk++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL cycle_outputs: got %b expected %b (rdy,bwe,wwe,brst,wrst,layer,busy,done,dr,drop) t=%0t",
               act_v, exp_v, $time);
    end
    if (biasWriteEn) bw_cnt++;
    if (weightWriteEn) ww_cnt++;
    if (biasRst) clr_cnt++;
    if (startDropped) drop_cnt++;
    if (loadDone) begin done_cnt++; done_cyc = cyc; end
    if (!rst) begin
      m_clr  = ena && m_ph == P_IDLE && loadStart;
      m_drop = ena && m_ph != P_IDLE && loadStart;
      if (ena) begin
        case (m_ph)
          P_IDLE: if (loadStart) begin
            m_b = int'(biasCount); m_w = int'(weightCount); m_layer = int'(loadLayer);
            m_dr = 0; m_ph = P_CLEAR;
          end
          P_CLEAR: begin
            if (m_b != 0) begin m_ph = P_BIAS; m_rem = m_b; end
            else if (m_w != 0) begin m_ph = P_WEIGHT; m_rem = m_w; end
            else begin m_ph = P_DONE; m_dr = 1; end
          end
          P_BIAS: if (pcieValid && !biasFull) begin
            m_rem--;
            if (m_rem == 0) begin
              if (m_w != 0) begin m_ph = P_WEIGHT; m_rem = m_w; end
              else begin m_ph = P_DONE; m_dr = 1; end
            end
          end
          P_WEIGHT: if (pcieValid && !weightFull) begin
            m_rem--;
            if (m_rem == 0) begin m_ph = P_DONE; m_dr = 1; end
          end
          default: m_ph = P_IDLE;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start(input int l, input int b, input int w);
    loadLayer = 4'(l); biasCount = W'(b); weightCount = W'(w);
    bw_cnt = 0; ww_cnt = 0; clr_cnt = 0;
    st_cyc = cyc;
    loadStart = 1'b1;
    tick();
    loadStart = 1'b0;
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (m_ph != p && n < 200) begin tick(); n++; end
    check("phase_timeout", int'(n < 200), 1);
  endtask

  task automatic wait_idle(input bit tog, input bit rnd);
    int n = 0;
    while (m_ph != P_IDLE && n < 400) begin
      if (tog) weightFull = ~weightFull;
      if (rnd) begin
        pcieValid  = ($urandom % 4) != 0;
        biasFull   = ($urandom % 4) == 0;
        weightFull = ($urandom % 4) == 0;
        ena        = ($urandom % 8) != 0;
        loadStart  = (m_ph == P_BIAS || m_ph == P_WEIGHT) && ($urandom % 10) == 0;
      end
      tick();
      n++;
    end
    loadStart = 1'b0; ena = 1'b1; biasFull = 1'b0; weightFull = 1'b0;
    check("load_timeout", int'(n < 400), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, b, w, hold;
    // 1) reset and idle
    tick(); tick();
    rst = 1'b0; ena = 1'b1;
    repeat (5) tick();
    check("idle_outputs", int'(outs()), 0);
    check("idle_busy", int'(loadBusy), 0);

    // 2) 3/5 with valid held
    pcieValid = 1'b1;
    start(1, 3, 5);
    wait_idle(0, 0);
    check("t2_bias_writes", bw_cnt, 3);
    check("t2_weight_writes", ww_cnt, 5);
    check("t2_clear_pulses", clr_cnt, 1);
    check("t2_start_to_done", done_cyc - st_cyc, 10);
    check("t2_data_ready", int'(pcieDataReady), 1);

    // 3) 2/4 with bias full stall and toggling weight full
    start(2, 2, 4);
    tick();
    biasFull = 1'b1;
    repeat (3) tick();
    biasFull = 1'b0;
    wait_idle(1, 0);
    check("t3_bias_writes", bw_cnt, 2);
    check("t3_weight_writes", ww_cnt, 4);

    // 4) zero counts
    start(3, 0, 0);
    wait_idle(0, 0);
    check("t4_zero_latency", done_cyc - st_cyc, 2);
    check("t4_zero_writes", bw_cnt + ww_cnt, 0);
    start(4, 0, 3);
    wait_idle(0, 0);
    check("t4_b0_bias", bw_cnt, 0);
    check("t4_b0_weight", ww_cnt, 3);

    // 5a) loadStart during WEIGHT is dropped
    start(5, 2, 6);
    wait_phase(P_WEIGHT);
    d0 = drop_cnt;
    biasCount = W'(7);
    loadStart = 1'b1; tick(); loadStart = 1'b0; tick();
    loadStart = 1'b1; tick(); loadStart = 1'b0;
    wait_idle(0, 0);
    check("t5_drops", drop_cnt - d0, 2);
    check("t5_bias_writes", bw_cnt, 2);
    check("t5_weight_writes", ww_cnt, 6);
    check("t5_layer", int'(curLayer), 5);

    // 5b) ena=0 mid-bias
    start(6, 4, 2);
    tick(); tick();
    ena = 1'b0;
    hold = bw_cnt;
    repeat (4) tick();
    check("t5_frozen_writes", bw_cnt, hold);
    check("t5_frozen_busy", int'(loadBusy), 1);
    ena = 1'b1;
    wait_idle(0, 0);
    check("t5_ena_bias", bw_cnt, 4);
    check("t5_ena_weight", ww_cnt, 2);

    // all-ones count
    start(7, 31, 1);
    wait_idle(0, 0);
    check("max_bias_writes", bw_cnt, 31);
    check("max_weight_writes", ww_cnt, 1);

    // 6) reset mid-WEIGHT
    start(8, 2, 5);
    wait_phase(P_WEIGHT);
    tick();
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("t6_async_outputs", int'(outs()), 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("t6_no_done", done_cnt, d0);
    start(9, 1, 1);
    wait_idle(0, 0);
    check("t6_layer", int'(curLayer), 9);
    check("t6_bias", bw_cnt, 1);
    check("t6_weight", ww_cnt, 1);
    check("t6_done", done_cnt, d0 + 1);

    // randomized loads
    for (int i = 0; i < 16; i++) begin
      b = $urandom_range(0, 6);
      w = $urandom_range(0, 6);
      d0 = done_cnt;
      pcieValid = 1'b1;
      start(i % 16, b, w);
      wait_idle(0, 1);
      check("rnd_bias", bw_cnt, b);
      check("rnd_weight", ww_cnt, w);
      check("rnd_done", done_cnt, d0 + 1);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
